bidir_bus_seq: RTL

- Sequences one half-duplex, DATA_W-bit bidirectional pad bus, such as a PZT driver DAC/ADC parallel port.
- Efinity cannot infer tri-states, so the pad is exposed as separate pad_i / pad_o / pad_oe signals. These wire to the periphery I/O buffer configured in the interface designer.
- Accepts single read or write requests and generates the strobe.
- Guarantees the bus is released (pad_oe=0) with TURN_CYC turnaround cycles before returning to idle, so the FPGA and the peripheral never drive simultaneously.

---
 rtl/bidir_bus_seq_pkg.sv | 22 ++
 rtl/bidir_bus_in_sync.sv | 25 ++
 rtl/bidir_bus_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bidir_bus_seq_pkg.sv
// Shared types and constants for the half-duplex pad bus sequencer.
package bidir_bus_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    STB,
    HOLD,
    RSTB,
    TURN
  } state_t;

  localparam int SYNC_STAGES = 2;

  // Phase counter width; leaves headroom for the synchronizer-lengthened read strobe.
  function automatic int cnt_w(input int stb_cyc, input int turn_cyc);
    int m;
    m = (stb_cyc > turn_cyc) ? stb_cyc : turn_cyc;
    return $clog2(m + 2);
  endfunction

endpackage

// File: rtl/bidir_bus_in_sync.sv
// DATA_W-wide multi-flop synchronizer for the pad input bus (used when BIDIR_BUS_SEQ_SYNC_EN is defined).
module bidir_bus_in_sync
  import bidir_bus_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_bus_seq.sv
// Single-transfer read/write sequencer for a half-duplex bidirectional pad bus with guaranteed turnaround.
// Define BIDIR_BUS_SEQ_SYNC_EN to synchronize pad_i before capture (read strobe grows by SYNC_STAGES cycles).
module bidir_bus_seq
  import bidir_bus_seq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int STB_CYC  = 2,
  parameter int TURN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              bus_stb,
  output logic              bus_wr,
  input  logic [DATA_W-1:0] pad_i,
  output logic [DATA_W-1:0] pad_o,
  output logic [DATA_W-1:0] pad_oe
);

  if (STB_CYC < 1 || TURN_CYC < 1) begin : g_param_err
    $error("bidir_bus_seq: STB_CYC and TURN_CYC must both be >= 1");
  end

`ifdef BIDIR_BUS_SEQ_SYNC_EN
  localparam int RSTB_CYC = STB_CYC + SYNC_STAGES;
`else
  localparam int RSTB_CYC = STB_CYC;
`endif

  localparam int CW = cnt_w(STB_CYC, TURN_CYC);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t STB_LOAD  = cnt_t'(STB_CYC - 1);
  localparam cnt_t RSTB_LOAD = cnt_t'(RSTB_CYC - 1);
  localparam cnt_t TURN_LOAD = cnt_t'(TURN_CYC - 1);

  state_t            state_reg, state_next;
  cnt_t              cnt_reg, cnt_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] cap_data;
  logic              accept;
  logic              capture;
  logic              drive_next;
  logic              ready_reg, oe_reg, stb_reg, wr_reg, busy_reg, rsp_valid_reg;
  logic [DATA_W-1:0] pad_o_reg, rsp_rdata_reg;

`ifdef BIDIR_BUS_SEQ_SYNC_EN
  bidir_bus_in_sync #(
    .DATA_W(DATA_W)
  ) u_in_sync (
    .clk(clk),
    .rst(rst),
    .d  (pad_i),
    .q  (cap_data)
  );
`else
  assign cap_data = pad_i;
`endif

  // ready_reg is only ever high in IDLE, so it doubles as the accept gate.
  assign accept     = req_valid && ready_reg && (state_reg == IDLE);
  assign capture    = (state_reg == RSTB) && (cnt_reg == '0);
  assign wdata_next = accept ? req_wdata : wdata_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = req_wr ? DRIVE : RSTB;
          cnt_next   = req_wr ? '0 : RSTB_LOAD;
        end
      end
      DRIVE: begin
        if (cnt_reg == '0) begin
          state_next = STB;
          cnt_next   = STB_LOAD;
        end
      end
      STB: begin
        if (cnt_reg == '0) begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      end
      HOLD, RSTB: begin
        if (cnt_reg == '0) begin
          state_next = TURN;
          cnt_next   = TURN_LOAD;
        end
      end
      TURN: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so each one lines up with its state.
  assign drive_next = (state_next == DRIVE) || (state_next == STB) || (state_next == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      wdata_reg     <= '0;
      ready_reg     <= 1'b0;
      oe_reg        <= 1'b0;
      stb_reg       <= 1'b0;
      wr_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      pad_o_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      wdata_reg     <= wdata_next;
      ready_reg     <= (state_next == IDLE);
      oe_reg        <= drive_next;
      stb_reg       <= (state_next == STB) || (state_next == RSTB);
      wr_reg        <= drive_next;
      busy_reg      <= (state_next != IDLE);
      pad_o_reg     <= drive_next ? wdata_next : '0;
      rsp_valid_reg <= capture;
      if (capture) begin
        rsp_rdata_reg <= cap_data;
      end
    end
  end

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign busy      = busy_reg;
  assign bus_stb   = stb_reg;
  assign bus_wr    = wr_reg;
  assign pad_o     = pad_o_reg;
  assign pad_oe    = {DATA_W{oe_reg}};

endmodule
